// File: rtl/noc_params.sv
// Shared NoC router parameters and types.
// PORT_SIZE is the index width for router ports; VC_SIZE for virtual channels.
package noc_params;

    localparam int unsigned PORT_NUM  = 5;
    localparam int unsigned VC_NUM    = 2;
    localparam int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 0,
        NORTH = 1,
        SOUTH = 2,
        WEST  = 3,
        EAST  = 4
    } port_t;

endpackage

// File: rtl/switch_allocator_rr.sv
// Round-robin arbiter with an internally held priority pointer.
// The pointer only advances when the owner signals that the current grant
// was actually used (update), so a winner that is later discarded keeps
// its priority for the next cycle.
module round_robin_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  request,
    input  logic          update,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;
    logic          found_hi;
    logic          found_lo;

    // Pick the first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx_hi    = '0;
        idx_lo    = '0;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (request[j]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = IW'(j);
                end
                if (!found_hi && (j >= 32'(ptr))) begin
                    found_hi = 1'b1;
                    idx_hi   = IW'(j);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        if (found_lo) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Move priority just past the used winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update && (|request)) begin
            ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: separable input-first round-robin allocation
// with per-output-VC downstream credit tracking.
// Optional macro SA_OUTPUT_REG_EN registers the grant outputs (one cycle
// later); credit and pointer state still update at the evaluation edge.
module switch_allocator
    import noc_params::*;
#(
    parameter int unsigned CREDIT_MAX = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]         request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]         out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
    input  logic  [PORT_NUM-1:0]                     credit_valid_i,
    input  logic  [PORT_NUM-1:0][VC_SIZE-1:0]        credit_vc_i,
    output logic  [PORT_NUM-1:0]                     valid_o,
    output logic  [PORT_NUM-1:0][VC_SIZE-1:0]        sel_vc_o,
    output logic  [PORT_NUM-1:0]                     xb_valid_o,
    output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]      xb_sel_o,
    output logic                                     error_o
);

    localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

    logic [PORT_NUM-1:0][VC_NUM-1:0][CW-1:0]    credit;
    logic [PORT_NUM-1:0][VC_NUM-1:0]            eligible;

    logic [PORT_NUM-1:0][VC_NUM-1:0]            vc_onehot;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]           vc_idx;
    logic [PORT_NUM-1:0]                        cand_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]         cand_port;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]           cand_dvc;

    logic [PORT_NUM-1:0][PORT_NUM-1:0]          req2;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]          out_onehot;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]         out_idx;
    logic [PORT_NUM-1:0]                        out_used;
    logic [PORT_NUM-1:0]                        in_grant;

    logic [PORT_NUM-1:0]                        valid_c;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]           sel_vc_c;
    logic [PORT_NUM-1:0]                        xb_valid_c;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]         xb_sel_c;

    logic [PORT_NUM-1:0][VC_NUM-1:0]            dec;
    logic [PORT_NUM-1:0][VC_NUM-1:0]            inc;

    // An input VC may compete only if its downstream VC has a free slot.
    always_comb begin
        eligible = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (request_i[p][v] && (32'(out_port_i[p][v]) < PORT_NUM)) begin
                    eligible[p][v] = (credit[out_port_i[p][v]][downstream_vc_i[p][v]] != '0);
                end
            end
        end
    end

    // Stage 1: one VC per input port.
    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_in
        round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk       (clk),
            .rst       (rst),
            .request   (eligible[gp]),
            .update    (in_grant[gp]),
            .grant     (vc_onehot[gp]),
            .grant_idx (vc_idx[gp])
        );
    end

    // Stage-1 candidate per input and the per-output request matrix.
    always_comb begin
        cand_valid = '0;
        cand_port  = '0;
        cand_dvc   = '0;
        req2       = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            cand_valid[p] = |vc_onehot[p];
            cand_port[p]  = out_port_i[p][vc_idx[p]];
            cand_dvc[p]   = downstream_vc_i[p][vc_idx[p]];
        end
        for (int unsigned q = 0; q < PORT_NUM; q++) begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                req2[q][p] = cand_valid[p] && (32'(cand_port[p]) == q);
            end
        end
    end

    // Stage 2: one input per output port; any contender means a grant.
    for (genvar gq = 0; gq < PORT_NUM; gq++) begin : g_out
        assign out_used[gq] = |req2[gq];
        round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
            .clk       (clk),
            .rst       (rst),
            .request   (req2[gq]),
            .update    (out_used[gq]),
            .grant     (out_onehot[gq]),
            .grant_idx (out_idx[gq])
        );
    end

    // Final grant per input: it won on whichever output it targeted.
    always_comb begin
        in_grant = '0;
        for (int unsigned q = 0; q < PORT_NUM; q++) begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                if (out_onehot[q][p]) begin
                    in_grant[p] = 1'b1;
                end
            end
        end
    end

    // Grant-side output values; ungranted ports drive zero.
    always_comb begin
        valid_c    = in_grant;
        sel_vc_c   = '0;
        xb_valid_c = out_used;
        xb_sel_c   = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (in_grant[p]) begin
                sel_vc_c[p] = vc_idx[p];
            end
        end
        for (int unsigned q = 0; q < PORT_NUM; q++) begin
            if (out_used[q]) begin
                xb_sel_c[q] = out_idx[q];
            end
        end
    end

    // Credit consumption by grants and replenishment by returns.
    always_comb begin
        dec = '0;
        inc = '0;
        for (int unsigned q = 0; q < PORT_NUM; q++) begin
            if (out_used[q]) begin
                dec[q][cand_dvc[out_idx[q]]] = 1'b1;
            end
            if (credit_valid_i[q]) begin
                inc[q][credit_vc_i[q]] = 1'b1;
            end
        end
    end

    // Credit counters with saturation and a sticky overflow/underflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned q = 0; q < PORT_NUM; q++) begin
                for (int unsigned v = 0; v < VC_NUM; v++) begin
                    credit[q][v] <= CW'(CREDIT_MAX);
                end
            end
            error_o <= 1'b0;
        end else begin
            for (int unsigned q = 0; q < PORT_NUM; q++) begin
                for (int unsigned v = 0; v < VC_NUM; v++) begin
                    if (inc[q][v] && !dec[q][v]) begin
                        if (credit[q][v] == CW'(CREDIT_MAX)) begin
                            error_o <= 1'b1;
                        end else begin
                            credit[q][v] <= credit[q][v] + 1'b1;
                        end
                    end else if (dec[q][v] && !inc[q][v]) begin
                        if (credit[q][v] == '0) begin
                            error_o <= 1'b1;
                        end else begin
                            credit[q][v] <= credit[q][v] - 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef SA_OUTPUT_REG_EN
    // Registered grant outputs, one cycle behind the requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= '0;
            sel_vc_o   <= '0;
            xb_valid_o <= '0;
            xb_sel_o   <= '0;
        end else begin
            valid_o    <= valid_c;
            sel_vc_o   <= sel_vc_c;
            xb_valid_o <= xb_valid_c;
            xb_sel_o   <= xb_sel_c;
        end
    end
`else
    // Combinational grant outputs, held at zero while reset is asserted.
    always_comb begin
        valid_o    = rst ? valid_c    : '0;
        sel_vc_o   = rst ? sel_vc_c   : '0;
        xb_valid_o = rst ? xb_valid_c : '0;
        xb_sel_o   = rst ? xb_sel_c   : '0;
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: a behavioural allocator model
// produces expected outputs per cycle, a monitor compares on the falling edge.
`timescale 1ns/1ps
module tb_switch_allocator;
    import noc_params::*;

    localparam int unsigned CREDIT_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
    logic  [PORT_NUM-1:0]                          credit_valid;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             credit_vc;
    logic  [PORT_NUM-1:0]                          valid;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             sel_vc;
    logic  [PORT_NUM-1:0]                          xb_valid;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xb_sel;
    logic                                          error;

    switch_allocator #(.CREDIT_MAX(CREDIT_MAX)) dut (
        .clk             (clk),
        .rst             (rst),
        .request_i       (request),
        .out_port_i      (out_port),
        .downstream_vc_i (dvc),
        .credit_valid_i  (credit_valid),
        .credit_vc_i     (credit_vc),
        .valid_o         (valid),
        .sel_vc_o        (sel_vc),
        .xb_valid_o      (xb_valid),
        .xb_sel_o        (xb_sel),
        .error_o         (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PORT_NUM-1:0]                valid;
        logic [PORT_NUM-1:0][VC_SIZE-1:0]   sel_vc;
        logic [PORT_NUM-1:0]                xb_valid;
        logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel;
        logic                               err;
    } exp_t;

    exp_t exp_q[$];
    exp_t prev_exp;
    int   total = 0;
    int   bad   = 0;

    // Reference state
    int credit_m [PORT_NUM][VC_NUM];
    int in_ptr_m [PORT_NUM];
    int out_ptr_m[PORT_NUM];
    bit err_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < PORT_NUM; q++) begin
            for (int v = 0; v < VC_NUM; v++) credit_m[q][v] = CREDIT_MAX;
            in_ptr_m[q]  = 0;
            out_ptr_m[q] = 0;
        end
        err_m    = 1'b0;
        prev_exp = '0;
    endtask

    task automatic clear_inputs();
        request      = '0;
        out_port     = '0;
        dvc          = '0;
        credit_valid = '0;
        credit_vc    = '0;
    endtask

    task automatic set_req(input int p, input int v, input int q, input int d);
        request[p][v]  = 1'b1;
        out_port[p][v] = port_t'(q);
        dvc[p][v]      = VC_SIZE'(d);
    endtask

    task automatic set_ret(input int q, input int d);
        credit_valid[q] = 1'b1;
        credit_vc[q]    = VC_SIZE'(d);
    endtask

    // Allocation for one cycle from the current inputs and reference state.
    task automatic model_step(output exp_t e);
        int cand_v[PORT_NUM];
        bit dec_m[PORT_NUM][VC_NUM];
        int win;
        int v;
        int p;
        e = '0;
        e.err = err_m;
        dec_m = '{default: 0};
        for (int i = 0; i < PORT_NUM; i++) begin
            cand_v[i] = -1;
            for (int k = 0; k < VC_NUM; k++) begin
                v = (in_ptr_m[i] + k) % VC_NUM;
                if (cand_v[i] < 0 && request[i][v] &&
                    credit_m[int'(out_port[i][v])][int'(dvc[i][v])] > 0)
                    cand_v[i] = v;
            end
        end
        for (int q = 0; q < PORT_NUM; q++) begin
            win = -1;
            for (int k = 0; k < PORT_NUM; k++) begin
                p = (out_ptr_m[q] + k) % PORT_NUM;
                if (win < 0 && cand_v[p] >= 0 && int'(out_port[p][cand_v[p]]) == q)
                    win = p;
            end
            if (win >= 0) begin
                e.xb_valid[q] = 1'b1;
                e.xb_sel[q]   = PORT_SIZE'(win);
                e.valid[win]  = 1'b1;
                e.sel_vc[win] = VC_SIZE'(cand_v[win]);
                dec_m[q][int'(dvc[win][cand_v[win]])] = 1'b1;
                in_ptr_m[win] = (cand_v[win] + 1) % VC_NUM;
                out_ptr_m[q]  = (win + 1) % PORT_NUM;
            end
        end
        for (int q = 0; q < PORT_NUM; q++) begin
            for (int d = 0; d < VC_NUM; d++) begin
                bit inc;
                inc = credit_valid[q] && (int'(credit_vc[q]) == d);
                if (inc && !dec_m[q][d]) begin
                    if (credit_m[q][d] == CREDIT_MAX) err_m = 1'b1;
                    else credit_m[q][d]++;
                end else if (dec_m[q][d] && !inc) begin
                    credit_m[q][d]--;
                end
            end
        end
    endtask

    // Issue the current inputs for one cycle and queue the expected response.
    task automatic step();
        exp_t e;
        model_step(e);
`ifdef SA_OUTPUT_REG_EN
        begin
            exp_t shown;
            shown     = prev_exp;
            shown.err = e.err;
            prev_exp  = e;
            exp_q.push_back(shown);
        end
`else
        exp_q.push_back(e);
`endif
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges; outputs must drop immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid",    64'(valid), 64'd0);
        check("rst_xb_valid", 64'(xb_valid), 64'd0);
        check("rst_sel",      64'({sel_vc, xb_sel}), 64'd0);
        check("rst_error",    64'(error), 64'd0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid",    64'(valid),    64'(e.valid));
                check("sel_vc",   64'(sel_vc),   64'(e.sel_vc));
                check("xb_valid", 64'(xb_valid), 64'(e.xb_valid));
                check("xb_sel",   64'(xb_sel),   64'(e.xb_sel));
                check("error",    64'(error),    64'(e.err));
            end
        end
    end

    initial begin
        int vc;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        do_reset();

        // Fairness on EAST with a credit returned every cycle.
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            set_req(0, 0, EAST, 0);
            set_req(1, 0, EAST, 0);
            set_ret(EAST, 0);
            step();
        end

        // Two VCs of input 2 to distinct outputs.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            set_req(2, 0, NORTH, 0);
            set_req(2, 1, WEST, 1);
            step();
        end

        // Credit exhaustion on (NORTH, 0), then a single return.
        do_reset();
        clear_inputs();
        set_req(0, 0, NORTH, 0);
        for (int c = 0; c < 10; c++) step();
        set_ret(NORTH, 0);
        step();
        credit_valid = '0;
        for (int c = 0; c < 3; c++) step();
        // A starved VC must not block its sibling.
        set_req(0, 1, SOUTH, 0);
        for (int c = 0; c < 3; c++) step();

        // Same-cycle grant and return, then exhaust to prove the count held.
        do_reset();
        clear_inputs();
        set_req(3, 1, SOUTH, 1);
        set_ret(SOUTH, 1);
        for (int c = 0; c < 3; c++) step();
        credit_valid = '0;
        for (int c = 0; c < 10; c++) step();
        clear_inputs();
        set_ret(LOCAL, 0);
        step();
        clear_inputs();
        for (int c = 0; c < 3; c++) step();

        // Random traffic with an asynchronous reset in the middle.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                clear_inputs();
                for (int p = 0; p < PORT_NUM; p++) begin
                    set_req(p, 0, EAST, 0);
                    set_req(p, 1, EAST, 1);
                end
                step();
                step();
                do_reset();
                for (int p = 0; p < PORT_NUM; p++) begin
                    set_req(p, 0, EAST, 0);
                    set_req(p, 1, EAST, 1);
                end
                step();
            end
            clear_inputs();
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(p, v, int'($urandom_range(PORT_NUM - 1, 0)),
                                int'($urandom_range(VC_NUM - 1, 0)));
                end
            end
            for (int q = 0; q < PORT_NUM; q++) begin
                if ($urandom_range(9, 0) < 4) begin
                    vc = int'($urandom_range(VC_NUM - 1, 0));
                    if (credit_m[q][vc] < CREDIT_MAX || $urandom_range(49, 0) == 0)
                        set_ret(q, vc);
                end
            end
            step();
        end

        clear_inputs();
        step();
        step();
        @(negedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
